// File: rtl/rgb_capture_gray_if.sv
// Camera byte stream and grayscale output stream of one stereo channel.
//   cam_enable : capture request towards the camera
//   cam_valid  : cam_data carries a byte this cycle
//   cam_data   : camera bytes, R,G,B per pixel in raster order
//   gray_data  : grayscale pixel, held between strobes
//   gray_valid : one-cycle strobe per gray pixel
//   gray_done  : one-cycle pulse after the last gray pixel of a frame
// master = the capture/convert block, slave = camera plus downstream consumer.
interface rgb_capture_gray_if;
  logic       cam_enable;
  logic       cam_valid;
  logic [7:0] cam_data;
  logic [7:0] gray_data;
  logic       gray_valid;
  logic       gray_done;

  modport master (
    output cam_enable, gray_data, gray_valid, gray_done,
    input  cam_valid, cam_data
  );

  modport slave (
    input  cam_enable, gray_data, gray_valid, gray_done,
    output cam_valid, cam_data
  );
endinterface

// File: rtl/rgb_capture_gray.sv
// Camera front-end: captures one RGB frame into a byte memory, then reads it
// back and converts every pixel to 8-bit grayscale.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begins a frame (honoured in IDLE or DONE only)
//   clear      : synchronous abort back to IDLE (wins over start)
//   busy       : high while capturing or converting
//   bus        : camera input stream and gray output stream (master side)
// Build option: define GRAY_ROUND_EN for rounded, clamped gray conversion;
// the default build truncates. Timing is the same in both builds.
module rgb_capture_gray #(
  parameter int unsigned IMG_W = 4,
  parameter int unsigned IMG_H = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clear,
  output logic                busy,
  rgb_capture_gray_if.master  bus
);

  localparam int unsigned NPIX      = IMG_W * IMG_H;
  localparam int unsigned MEM_DEPTH = 3 * NPIX;
  localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);
  localparam int unsigned PIX_W     = $clog2(NPIX + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NPIX - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_fin;    // every address of the frame has been issued
  logic              rd_vld;    // rd_data holds a byte read last cycle
  logic [7:0]        rd_data;
  logic [1:0]        byte_cnt;  // 0=R, 1=G, 2=B
  logic [7:0]        r_reg;
  logic [7:0]        g_reg;
  logic [PIX_W-1:0]  pix_cnt;
  logic              gray_last; // current gray strobe is the frame's last
  logic [7:0]        gray_calc;
  logic              wr_en;
  logic              rd_en;

  logic [7:0] mem [MEM_DEPTH];

  assign wr_en          = (state == S_CAPTURE) && bus.cam_valid && !clear;
  assign rd_en          = (state == S_CONVERT) && !rd_fin;
  assign busy           = (state == S_CAPTURE) || (state == S_CONVERT);
  assign bus.cam_enable = (state == S_CAPTURE);

  // B is taken straight from the memory output, so the gray value is ready
  // in the same cycle the B byte appears.
  always_comb begin
    logic [15:0] sum;
    sum = 16'd77  * {8'd0, r_reg}
        + 16'd150 * {8'd0, g_reg}
        + 16'd29  * {8'd0, rd_data};
`ifdef GRAY_ROUND_EN
    begin
      logic [16:0] sum_r;
      sum_r     = {1'b0, sum} + 17'd128;
      gray_calc = sum_r[16] ? 8'hFF : 8'(sum_r >> 8);
    end
`else
    gray_calc = 8'(sum >> 8);
`endif
  end

  // Frame memory: not reset, untouched by clear.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= bus.cam_data;
    if (rd_en)
      rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rd_fin         <= 1'b0;
      rd_vld         <= 1'b0;
      byte_cnt       <= '0;
      r_reg          <= '0;
      g_reg          <= '0;
      pix_cnt        <= '0;
      gray_last      <= 1'b0;
      bus.gray_data  <= '0;
      bus.gray_valid <= 1'b0;
      bus.gray_done  <= 1'b0;
    end else if (clear) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rd_fin         <= 1'b0;
      rd_vld         <= 1'b0;
      byte_cnt       <= '0;
      pix_cnt        <= '0;
      gray_last      <= 1'b0;
      bus.gray_valid <= 1'b0;
      bus.gray_done  <= 1'b0;
    end else begin
      bus.gray_valid <= 1'b0;
      bus.gray_done  <= 1'b0;
      rd_vld         <= rd_en;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state  <= S_CAPTURE;
            wr_ptr <= '0;
          end
        end

        S_CAPTURE: begin
          if (wr_en) begin
            if (wr_ptr == LAST_ADDR) begin
              state    <= S_CONVERT;
              wr_ptr   <= '0;
              rd_ptr   <= '0;
              rd_fin   <= 1'b0;
              byte_cnt <= '0;
              pix_cnt  <= '0;
            end else begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
          end
        end

        S_CONVERT: begin
          if (rd_en) begin
            if (rd_ptr == LAST_ADDR)
              rd_fin <= 1'b1;
            else
              rd_ptr <= rd_ptr + ADDR_W'(1);
          end

          if (rd_vld) begin
            case (byte_cnt)
              2'd0: begin
                r_reg    <= rd_data;
                byte_cnt <= 2'd1;
              end
              2'd1: begin
                g_reg    <= rd_data;
                byte_cnt <= 2'd2;
              end
              default: begin
                bus.gray_data  <= gray_calc;
                bus.gray_valid <= 1'b1;
                gray_last      <= (pix_cnt == LAST_PIX);
                pix_cnt        <= pix_cnt + PIX_W'(1);
                byte_cnt       <= 2'd0;
              end
            endcase
          end

          // Leaving during the last strobe puts gray_done and DONE in the
          // following cycle.
          if (bus.gray_valid && gray_last) begin
            state         <= S_DONE;
            gray_last     <= 1'b0;
            bus.gray_done <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_capture_gray.sv
// Self-checking bench for rgb_capture_gray (4x4 frame).
module tb_rgb_capture_gray;

  localparam int NPIX      = 16;
  localparam int MEM_DEPTH = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic busy;

  rgb_capture_gray_if bus();

  rgb_capture_gray #(.IMG_W(4), .IMG_H(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int q_data[$];
  int q_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int held     = 0;
  bit held_ok  = 0;
  int conv_cyc = 0;

  logic [7:0] img [MEM_DEPTH];

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         exp;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: gray from the weighted-sum formula.
  function automatic int gray_ref(input int r, input int g, input int b);
    int s;
    s = 77 * r + 150 * g + 29 * b;
`ifdef GRAY_ROUND_EN
    s = s + 128;
`endif
    s = s / 256;
    if (s > 255) s = 255;
    return s;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gray_valid) begin
        q_data.push_back(int'(bus.gray_data));
        q_cyc.push_back(cyc);
        held    = int'(bus.gray_data);
        held_ok = 1;
      end else if (held_ok) begin
        check("gray_hold", int'(bus.gray_data), held);
      end
      if (bus.gray_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy_low", int'(busy), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // stall: 0 none, 1 alternate idle cycle, 2 random idle cycles.
  // abort_at > 0: clear once that many gray strobes have been seen.
  task automatic run_frame(input int stall, input bit extra_start, input int abort_at);
    int waited;
    q_data.delete();
    q_cyc.delete();
    done_cnt = 0;

    start = 1'b1;
    tick();
    start = 1'b0;
    check("capture_enable", int'(bus.cam_enable), 1);
    check("capture_busy", int'(busy), 1);

    for (int i = 0; i < MEM_DEPTH; i++) begin
      if ((stall == 1 && i > 0) || (stall == 2 && $urandom_range(0, 2) == 0)) begin
        bus.cam_valid = 1'b0;
        tick();
      end
      bus.cam_valid = 1'b1;
      bus.cam_data  = img[i];
      if (extra_start && i == 20) start = 1'b1;
      tick();
      start = 1'b0;
    end
    bus.cam_valid = 1'b0;
    conv_cyc = cyc;
    check("cam_enable_drop", int'(bus.cam_enable), 0);
    check("convert_busy", int'(busy), 1);

    if (extra_start) begin
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end

    if (abort_at > 0) begin
      waited = 0;
      while (q_data.size() < abort_at && waited < 300) begin
        tick();
        waited++;
      end
      check("abort_reach", int'(q_data.size() >= abort_at), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (60) tick();
      check("abort_no_more_valid", q_data.size(), abort_at);
      check("abort_no_done", done_cnt, 0);
      check("abort_busy", int'(busy), 0);
      check("abort_cam_enable", int'(bus.cam_enable), 0);
      return;
    end

    waited = 0;
    while (done_cnt == 0 && waited < 300) begin
      tick();
      waited++;
    end
    check("done_timeout", int'(done_cnt > 0), 1);
    repeat (10) tick();

    check("strobe_count", q_data.size(), NPIX);
    check("done_count", done_cnt, 1);
    check("end_busy", int'(busy), 0);
    if (q_cyc.size() > 0) begin
      check("first_latency", q_cyc[0] - conv_cyc, 4);
      check("done_after_last", done_cyc - q_cyc[q_cyc.size() - 1], 1);
    end
    for (int k = 0; k < NPIX && k < q_data.size(); k++) begin
      check($sformatf("gray_px%0d", k), q_data[k],
            gray_ref(int'(img[3*k]), int'(img[3*k+1]), int'(img[3*k+2])));
      if (k > 0)
        check($sformatf("spacing_px%0d", k), q_cyc[k] - q_cyc[k-1], 3);
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < MEM_DEPTH; i++) img[i] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < MEM_DEPTH; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int bad;
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_bad;
    bus.cam_valid = 1'b0;
    bus.cam_data  = '0;

    tbl[0] = '{r: 8'd255, g: 8'd0,  b: 8'd0,  exp: 76};
    tbl[1] = '{r: 8'd10,  g: 8'd20, b: 8'd30, exp: 18};
    tbl[2] = '{r: 8'd0,   g: 8'd1,  b: 8'd0,  exp: 0};
    tbl[3] = '{r: 8'd0,   g: 8'd0,  b: 8'd0,  exp: 0};
`ifdef GRAY_ROUND_EN
    tbl[0].exp = 77;
    tbl[2].exp = 1;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cam_enable", int'(bus.cam_enable), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_gray_valid", int'(bus.gray_valid), 0);
    check("rst_gray_done", int'(bus.gray_done), 0);
    check("rst_gray_data", int'(bus.gray_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle for 50 cycles with no start
    idle_bad = 0;
    repeat (50) begin
      tick();
      if (busy || bus.cam_enable) idle_bad++;
    end
    check("idle_active", idle_bad, 0);
    check("idle_strobes", q_data.size(), 0);
    check("idle_done", done_cnt, 0);

    // Basic all-white frame
    fill_const(8'd255);
    run_frame(0, 1'b0, 0);
    for (int k = 0; k < q_data.size(); k++)
      check("white_px", q_data[k], 255);

    // Arithmetic table
    for (int k = 0; k < NPIX; k++) begin
      img[3*k]   = tbl[k % 4].r;
      img[3*k+1] = tbl[k % 4].g;
      img[3*k+2] = tbl[k % 4].b;
    end
    run_frame(0, 1'b0, 0);
    for (int k = 0; k < NPIX && k < q_data.size(); k++)
      check($sformatf("table_px%0d", k), q_data[k], tbl[k % 4].exp);

    // Stalled camera, white frame
    fill_const(8'd255);
    run_frame(1, 1'b0, 0);
    for (int k = 0; k < q_data.size(); k++)
      check("stall_white_px", q_data[k], 255);

    // Abort after 8 strobes, then a full frame
    fill_random();
    run_frame(0, 1'b0, 8);
    fill_random();
    run_frame(0, 1'b0, 0);

    // Start pulses during CAPTURE and CONVERT are ignored
    fill_random();
    run_frame(0, 1'b1, 0);

    // Random frames with random stalls
    for (int f = 0; f < 2; f++) begin
      fill_random();
      run_frame(2, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
